// File: rtl/ctrl_pkg.sv
// Shared types and constants for the control unit: opcodes, select codes,
// FSM states, instruction field positions and decode record.
package ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ALU  = 4'd1,
    OP_ADDI = 4'd2,
    OP_LUI  = 4'd3,
    OP_LD   = 4'd4,
    OP_JAL  = 4'd5,
    OP_JR   = 4'd6,
    OP_HALT = 4'd15
  } opcode_e;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_XOR   = 3'd4;
  localparam logic [2:0] ALU_SLL   = 3'd5;
  localparam logic [2:0] ALU_SRL   = 3'd6;
  localparam logic [2:0] ALU_PASSB = 3'd7;

  localparam logic [2:0] OPS_RY     = 3'd0;
  localparam logic [2:0] OPS_IMM    = 3'd1;
  localparam logic [2:0] OPS_IMM_HI = 3'd2;

  localparam logic [2:0] DS_ALU = 3'd0;
  localparam logic [2:0] DS_MEM = 3'd1;
  localparam logic [2:0] DS_PC  = 3'd2;

  localparam logic [2:0] PC_ALU  = 3'd0;
  localparam logic [2:0] PC_REL  = 3'd1;
  localparam logic [2:0] PC_INC  = 3'd2;
  localparam logic [2:0] PC_HOLD = 3'd3;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
  } state_e;

  localparam int OP_HI  = 15, OP_LO  = 12;
  localparam int RZ_HI  = 11, RZ_LO  = 9;
  localparam int RX_HI  = 8,  RX_LO  = 6;
  localparam int RY_HI  = 5,  RY_LO  = 3;
  localparam int FN_HI  = 2,  FN_LO  = 0;
  localparam int IMM_HI = 5,  IMM_LO = 0;

  // Execution class: what EXEC does with the instruction.
  typedef enum logic [2:0] {
    CL_NOP, CL_REG, CL_JAL, CL_JR, CL_LD, CL_HALT, CL_ILL
  } iclass_e;

  typedef struct packed {
    iclass_e    cls;
    logic [2:0] rz;
    logic [2:0] rx;
    logic [2:0] ry;
    logic [2:0] alu;
    logic [2:0] op_s;
    logic [2:0] data_s;
    logic [5:0] imm;
  } dec_t;

  function automatic logic exec_we(iclass_e c);
    logic we;
    we = (c == CL_REG) || (c == CL_JAL);
    return we;
  endfunction

  function automatic logic [2:0] exec_pc(iclass_e c);
    logic [2:0] sel;
    case (c)
      CL_NOP, CL_REG, CL_ILL: sel = PC_INC;
      CL_JAL:                 sel = PC_REL;
      CL_JR:                  sel = PC_ALU;
      default:                sel = PC_HOLD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: splits IR into register fields,
// immediate, ALU op, operand/write-data selects and the execution class.
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [15:0] ir_i,
  output dec_t        dec_o
);

  logic [3:0] op;
  assign op = ir_i[OP_HI:OP_LO];

  always_comb begin
    dec_o        = '0;
    dec_o.rz     = ir_i[RZ_HI:RZ_LO];
    dec_o.rx     = ir_i[RX_HI:RX_LO];
    dec_o.ry     = ir_i[RY_HI:RY_LO];
    dec_o.imm    = ir_i[IMM_HI:IMM_LO];
    dec_o.alu    = ALU_ADD;
    dec_o.op_s   = OPS_RY;
    dec_o.data_s = DS_ALU;
    case (op)
      OP_NOP:  dec_o.cls = CL_NOP;
      OP_ALU: begin
        dec_o.cls = CL_REG;
        dec_o.alu = ir_i[FN_HI:FN_LO];
      end
      OP_ADDI: begin
        dec_o.cls  = CL_REG;
        dec_o.op_s = OPS_IMM;
      end
      OP_LUI: begin
        dec_o.cls  = CL_REG;
        dec_o.alu  = ALU_OR;
        dec_o.op_s = OPS_IMM_HI;
      end
      OP_LD: begin
        dec_o.cls    = CL_LD;
        dec_o.op_s   = OPS_IMM;
        dec_o.data_s = DS_MEM;
      end
      OP_JAL: begin
        dec_o.cls    = CL_JAL;
        dec_o.op_s   = OPS_IMM;
        dec_o.data_s = DS_PC;
      end
      OP_JR: begin
        dec_o.cls  = CL_JR;
        dec_o.op_s = OPS_IMM;
      end
      OP_HALT: dec_o.cls = CL_HALT;
      default: dec_o.cls = CL_ILL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer FETCH/DECODE/EXEC[/MEM/WB] for the 16-bit datapath.
// Define CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes in TRAP with fault set.
module control_unit
  import ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        dmem_req,
  input  logic        dmem_ack,
  output logic [2:0]  rX_address,
  output logic [2:0]  rY_address,
  output logic [2:0]  rZ_address,
  output logic [2:0]  alu_ctr,
  output logic [2:0]  operand_s,
  output logic [2:0]  data_s,
  output logic [2:0]  pc_s,
  output logic        clk_en,
  output logic [5:0]  immediate,
  output logic        halted,
  output logic        fault
);

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_e      state_q;
  logic [15:0] ir_q;
  logic [2:0]  rx_q, ry_q, rz_q, alu_q, ops_q, ds_q, pcs_q;
  logic [5:0]  imm_q;
  logic        we_q, dreq_q, halted_q;
  dec_t        dec;

  instr_decoder u_dec (
    .ir_i  (ir_q),
    .dec_o (dec)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      ir_q     <= '0;
      rx_q     <= '0;
      ry_q     <= '0;
      rz_q     <= '0;
      alu_q    <= '0;
      ops_q    <= '0;
      ds_q     <= '0;
      imm_q    <= '0;
      pcs_q    <= PC_HOLD;
      we_q     <= 1'b0;
      dreq_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      // Strobes live for a single cycle unless a state re-arms them.
      we_q  <= 1'b0;
      pcs_q <= PC_HOLD;
      case (state_q)
        S_FETCH: begin
          if (run && imem_ack) begin
            ir_q    <= imem_rdata;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          rx_q    <= dec.rx;
          ry_q    <= dec.ry;
          rz_q    <= dec.rz;
          alu_q   <= dec.alu;
          ops_q   <= dec.op_s;
          ds_q    <= dec.data_s;
          imm_q   <= dec.imm;
          we_q    <= exec_we(dec.cls);
          pcs_q   <= (TRAP_EN && dec.cls == CL_ILL) ? PC_HOLD : exec_pc(dec.cls);
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          case (dec.cls)
            CL_LD: begin
              dreq_q  <= 1'b1;
              state_q <= S_MEM;
            end
            CL_HALT: begin
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end
            CL_ILL:  state_q <= TRAP_EN ? S_TRAP : S_FETCH;
            default: state_q <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (dmem_ack) begin
            dreq_q  <= 1'b0;
            we_q    <= 1'b1;
            ds_q    <= DS_MEM;
            pcs_q   <= PC_INC;
            state_q <= S_WB;
          end
        end
        S_WB:            state_q <= S_FETCH;
        S_HALT, S_TRAP:  state_q <= state_q;
        default:         state_q <= S_FETCH;
      endcase
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic fault_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                           fault_q <= 1'b0;
    else if (state_q == S_EXEC && dec.cls == CL_ILL)     fault_q <= 1'b1;
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  // Reset gates the request combinationally so it drops the moment reset rises.
  assign imem_req   = (state_q == S_FETCH) && run && !reset;
  assign dmem_req   = dreq_q;
  assign rX_address = rx_q;
  assign rY_address = ry_q;
  assign rZ_address = rz_q;
  assign alu_ctr    = alu_q;
  assign operand_s  = ops_q;
  assign data_s     = ds_q;
  // The datapath's pc_mux input 3 must feed back the current PC (hold).
  assign pc_s       = pcs_q;
  assign clk_en     = we_q;
  assign immediate  = imm_q;
  assign halted     = halted_q;

endmodule
